// File: rtl/multiply_result_sign_restore.sv
// Post-multiply sign restore: bit-serial LSB-first two's-complement negation of the product magnitude.
// Optional signed-overflow flag enabled by defining MULTIPLY_RESTORE_OVF_EN.
module multiply_result_sign_restore #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_restore_sel,
  input  logic [WIDTH-1:0] i_product_reg,
  input  logic             i_first_sign,
  input  logic             i_second_sign,
  output logic [WIDTH-1:0] o_result,
  output logic             o_result_neg,
  output logic             o_result_ovf,
  output logic             o_busy,
  output logic             o_restore_finish
);

  // state     | meaning
  // S_IDLE    | waiting for restore_sel
  // S_CONVERT | one result bit per clock, LSB first
  // S_DONE    | result valid, waiting for restore_sel to drop
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_p_cap;
  logic             r_neg_cap;
  logic [IW-1:0]    r_idx;
  logic             r_carry;

  logic w_bit_in;
  logic w_res_bit;
  logic w_last;

  assign w_bit_in  = r_p_cap[r_idx];
  assign w_res_bit = r_neg_cap ? (~w_bit_in ^ r_carry) : w_bit_in;
  assign w_last    = (r_idx == LAST_IDX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_p_cap          <= '0;
      r_neg_cap        <= 1'b0;
      r_idx            <= '0;
      r_carry          <= 1'b0;
      o_result         <= '0;
      o_result_neg     <= 1'b0;
      o_busy           <= 1'b0;
      o_restore_finish <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_restore_sel) begin
            r_p_cap          <= i_product_reg;
            r_neg_cap        <= i_first_sign ^ i_second_sign;
            r_idx            <= '0;
            r_carry          <= 1'b1;
            o_busy           <= 1'b1;
            o_restore_finish <= 1'b0;
            r_state          <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          o_result[r_idx] <= w_res_bit;
          if (r_neg_cap) begin
            r_carry <= ~w_bit_in & r_carry;
          end
          if (w_last) begin
            o_busy           <= 1'b0;
            o_restore_finish <= 1'b1;
            // A zero magnitude negates to zero, so it is never reported as negative.
            o_result_neg     <= r_neg_cap & (|r_p_cap);
            r_state          <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (!i_restore_sel) begin
            o_restore_finish <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef MULTIPLY_RESTORE_OVF_EN
  logic w_ovf;

  // Magnitude 2^(WIDTH-1) is representable only as a negative value.
  assign w_ovf = r_neg_cap ? (r_p_cap[WIDTH-1] & (|r_p_cap[WIDTH-2:0]))
                           : r_p_cap[WIDTH-1];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_result_ovf <= 1'b0;
    end else if (r_state == S_CONVERT && w_last) begin
      o_result_ovf <= w_ovf;
    end
  end
`else
  assign o_result_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_multiply_result_sign_restore.sv
// Scoreboard bench for multiply_result_sign_restore: driver queues expected results, monitor checks on restore_finish.
module tb_multiply_result_sign_restore;

  localparam int WIDTH = 8;
`ifdef MULTIPLY_RESTORE_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             restore_sel = 1'b0;
  logic [WIDTH-1:0] product_reg = '0;
  logic             first_sign = 1'b0;
  logic             second_sign = 1'b0;
  logic [WIDTH-1:0] result;
  logic             result_neg;
  logic             result_ovf;
  logic             busy;
  logic             restore_finish;

  multiply_result_sign_restore #(.WIDTH(WIDTH)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_restore_sel   (restore_sel),
    .i_product_reg   (product_reg),
    .i_first_sign    (first_sign),
    .i_second_sign   (second_sign),
    .o_result        (result),
    .o_result_neg    (result_neg),
    .o_result_ovf    (result_ovf),
    .o_busy          (busy),
    .o_restore_finish(restore_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             neg;
    logic             ovf;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] prod;
    logic             s1;
    logic             s2;
    logic [WIDTH-1:0] res;
    logic             neg;
    logic             ovf;
  } vec_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic prev_finish = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, ".result"}, 32'(result), 32'h0);
    chk({name, ".neg"}, 32'(result_neg), 32'h0);
    chk({name, ".ovf"}, 32'(result_ovf), 32'h0);
    chk({name, ".busy"}, 32'(busy), 32'h0);
    chk({name, ".finish"}, 32'(restore_finish), 32'h0);
  endtask

  // Monitor: checks each rising restore_finish against the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && restore_finish && !prev_finish) begin
      if (exp_q.size() == 0) begin
        chk("sb.unexpected_finish", 32'(restore_finish), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb.result", 32'(result), 32'(e.res));
        chk("sb.result_neg", 32'(result_neg), 32'(e.neg));
        chk("sb.result_ovf", 32'(result_ovf), 32'(e.ovf));
      end
    end
    prev_finish = restore_finish;
  end

  // Starts a conversion, garbles inputs during CONVERT, measures latency, holds sel in DONE, then releases.
  task automatic run_conv(input vec_t v, input int hold_cycles);
    int   lat;
    exp_t e;
    e.res = v.res;
    e.neg = v.neg;
    e.ovf = v.ovf & OVF_ON;
    exp_q.push_back(e);
    @(negedge clk);
    product_reg = v.prod;
    first_sign  = v.s1;
    second_sign = v.s2;
    restore_sel = 1'b1;
    @(posedge clk);
    #1;
    chk("start.busy", 32'(busy), 32'h1);
    chk("start.finish", 32'(restore_finish), 32'h0);
    @(negedge clk);
    product_reg = 8'hFF;
    first_sign  = ~v.s1;
    lat = 0;
    while (!restore_finish && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      chk("done_hold.busy", 32'(busy), 32'h0);
      chk("done_hold.finish", 32'(restore_finish), 32'h1);
    end
    @(negedge clk);
    restore_sel = 1'b0;
    @(posedge clk);
    #1;
    chk("release.finish", 32'(restore_finish), 32'h0);
    chk("release.result_kept", 32'(result), 32'(v.res));
    chk("release.neg_kept", 32'(result_neg), 32'(v.neg));
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    #3;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle.finish", 32'(restore_finish), 32'h0);
    end

    //            prod   s1    s2    result  neg   ovf
    vecs.push_back('{8'h0C, 1'b1, 1'b0, 8'hF4, 1'b1, 1'b0});
    vecs.push_back('{8'h40, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0});
    vecs.push_back('{8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0});
    vecs.push_back('{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1});
    vecs.push_back('{8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b0});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1});
    foreach (vecs[i]) run_conv(vecs[i], (i == 0) ? 5 : 1);

    // Async reset while sitting in DONE with non-zero outputs.
    v = '{8'h0C, 1'b1, 1'b0, 8'hF4, 1'b1, 1'b0};
    exp_q.push_back('{8'hF4, 1'b1, 1'b0});
    @(negedge clk);
    product_reg = v.prod;
    first_sign  = v.s1;
    second_sign = v.s2;
    restore_sel = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("pre_rst.finish", 32'(restore_finish), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst_done");
    restore_sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Abort after four conversion edges; no result may surface.
    @(negedge clk);
    product_reg = 8'h05;
    first_sign  = 1'b1;
    second_sign = 1'b0;
    restore_sel = 1'b1;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("abort_rst");
    restore_sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort.no_finish", 32'(restore_finish), 32'h0);

    run_conv('{8'h05, 1'b1, 1'b0, 8'hFB, 1'b1, 1'b0}, 1);

    repeat (2) @(posedge clk);
    chk("sb.queue_empty", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/multiply_result_sign_restore.md
Name: multiply_result_sign_restore

Overview:
- Post-multiply stage of the calculator datapath; the inverse of the pre-multiply two's-complement conversion of the 4-bit operands.
- Takes the unsigned product magnitude and the two operand sign bits. Applies two's-complement negation when the signs differ, producing the signed result.
- Conversion is bit-serial, LSB first: one bit per clock, with a ripple carry held in a register.
- Start/finish level handshake matches the other multiply stages.

Parameters:
- WIDTH, 8, product and result width in bits (must be ≥ 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- restore_sel  in  1  start request; level, held by the controller until restore_finish is seen.
- product_reg  in  WIDTH  unsigned product magnitude.
- first_sign  in  1  sign of first operand (1 = negative).
- second_sign  in  1  sign of second operand.
- result  out  WIDTH  signed two's-complement result (reg).
- result_neg  out  1  result is negative (reg).
- result_ovf  out  1  signed overflow flag (reg; see Optional Feature).
- busy  out  1  conversion in progress (reg).
- restore_finish  out  1  result valid (reg).

Behaviour:
- Reset: rst is asynchronous and active-high; one clock, clk.
  - All outputs go to 0 immediately.
  - State goes to IDLE; internal capture register, bit counter and carry are cleared.
- States: IDLE, CONVERT, DONE.
- IDLE:
  - When restore_sel=1 at a clk edge: capture product_reg into p_cap, set neg_cap = first_sign ^ second_sign, bit index = 0, carry = 1, busy <= 1, restore_finish <= 0.
  - Then go to CONVERT.
- CONVERT: each edge processes bit i = bit index.
  - If neg_cap: result[i] <= ~p_cap[i] ^ carry; carry <= ~p_cap[i] & carry.
  - Else: result[i] <= p_cap[i].
  - After bit WIDTH-1 is processed on the same edge: busy <= 0, restore_finish <= 1, result_neg <= neg_cap & (p_cap != 0), and state goes to DONE.
- Latency: restore_sel sampled at edge k gives restore_finish=1 after edge k+WIDTH.
- Inputs during CONVERT: restore_sel, product_reg and the sign inputs are ignored; captured values are used.
- DONE:
  - result, result_neg, result_ovf and restore_finish are held.
  - On restore_sel=0: restore_finish <= 0 and go to IDLE. result and flags are retained until the next start.
  - restore_sel held high in DONE never restarts a conversion.
- Zero product with neg_cap=1: result = 0 and result_neg = 0 (no negative zero).
- Wrap: product 2^(WIDTH-1) with neg_cap=1 gives result 2^(WIDTH-1). This is the exact encoding of -2^(WIDTH-1).
- Reset mid-CONVERT: the conversion is aborted with no partial result kept. The next restore_sel starts a fresh conversion.
- Bits of result not yet processed during CONVERT are undefined to consumers; only sample result when restore_finish=1.

Optional Feature:
- Macro: MULTIPLY_RESTORE_OVF_EN.
- Defined: result_ovf is registered on the DONE transition, edge k+WIDTH.
  - result_ovf = 1 when neg_cap=0 and p_cap > 2^(WIDTH-1)-1.
  - result_ovf = 1 when neg_cap=1 and p_cap > 2^(WIDTH-1).
  - Otherwise result_ovf = 0. It is held in DONE and cleared by reset only or by the next DONE update.
- Undefined: the result_ovf port stays present but is constantly 0. No comparator logic is built.

Test Plan:
All cases use WIDTH=8 and MULTIPLY_RESTORE_OVF_EN defined unless stated.
1. Reset: assert rst asynchronously mid-cycle → all outputs 0 before the next edge; release, idle 10 cycles → restore_finish stays 0.
2. Negative result (-3×4): product_reg=0x0C, first_sign=1, second_sign=0, restore_sel=1 at edge k → busy=1 after k; restore_finish=1 after edge k+8, result=0xF4, result_neg=1, result_ovf=0.
3. Positive result (-8×-8): product_reg=0x40, signs 1,1 → result=0x40, result_neg=0; change product_reg to 0xFF during CONVERT → result still 0x40.
4. Negative zero suppression: product_reg=0x00, signs 0,1 → result=0x00, result_neg=0. Boundary: product_reg=0x80, signs 1,0 → result=0x80, result_ovf=0.
5. Reset mid-operation, then restart: start with product 0x05 and signs 1,0; assert rst after 4 conversion edges → outputs 0, state IDLE. Restart with product 0x05 → result=0xFB after 8 further edges.
6. Handshake and overflow:
   - Keep restore_sel=1 for 5 cycles in DONE → no new busy pulse.
   - Drop restore_sel → restore_finish=0 one edge later, result retained.
   - product 0x81 with signs 0,0 → result_ovf=1.
   - With the macro undefined, the same case gives result_ovf=0.
